// File: rtl/multicycle_alu_pkg.sv
// Shared opcodes, FSM state type and flag bundle for the multicycle ALU.
package alu_pkg;

  localparam logic [6:0] OP_OR  = 7'd0;
  localparam logic [6:0] OP_AND = 7'd1;
  localparam logic [6:0] OP_XOR = 7'd2;
  localparam logic [6:0] OP_ADD = 7'd3;
  localparam logic [6:0] OP_SUB = 7'd4;
  localparam logic [6:0] OP_SHL = 7'd5;
  localparam logic [6:0] OP_SHR = 7'd6;
  localparam logic [6:0] OP_SRA = 7'd7;
  localparam logic [6:0] OP_MUL = 7'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic negative;
    logic zero;
    logic parity;
    logic overflow;
    logic illegal;
  } flags_t;

  function automatic logic isShift(input logic [6:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Operation request / result handshake bundle between the ALU and its neighbours.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [6:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             negative;
  logic             zero;
  logic             parity;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  carry, negative, zero, parity, overflow, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output carry, negative, zero, parity, overflow, illegal
  );

endinterface

// File: rtl/multicycle_alu_flags.sv
// Result-derived flags (sign, zero, parity); carry and overflow live in the parent.
module alu_flags #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result_i,
  output logic             negative_o,
  output logic             zero_o,
  output logic             parity_o
);

  assign negative_o = result_i[WIDTH-1];
  assign zero_o     = (result_i == '0);
  assign parity_o   = ^result_i;

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-step logic/add/sub, bit-serial shifts and shift-add multiply.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  multicycle_alu_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  state_t             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;

  logic               finish;
  logic [WIDTH-1:0]   resValue;
  logic               resCarry, resOverflow, resIllegal;
  logic               resNegative, resZero, resParity;
  logic [WIDTH:0]     addSum, subDiff, mulSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [WIDTH-1:0]   shiftStep;
  logic               shiftOut;
  logic [SHW-1:0]     shAmt;

  assign shAmt   = bus.b[SHW-1:0];
  assign addSum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign subDiff = {1'b0, bus.a} - {1'b0, bus.b};

  // Accumulator holds {partial high, remaining multiplier bits}; one right shift per step.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mulStep = {mulSum, acc_q[WIDTH-1:1]};

  always_comb begin
    shiftStep = {a_q[WIDTH-2:0], 1'b0};
    shiftOut  = a_q[WIDTH-1];
    case (op_q)
      OP_SHR: begin
        shiftStep = {1'b0, a_q[WIDTH-1:1]};
        shiftOut  = a_q[0];
      end
      OP_SRA: begin
        shiftStep = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        shiftOut  = a_q[0];
      end
      default: ;
    endcase
  end

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .result_i   (resValue),
    .negative_o (resNegative),
    .zero_o     (resZero),
    .parity_o   (resParity)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    count_d     = count_q;
    acc_d       = acc_q;
    result_d    = result_q;
    flags_d     = flags_q;
    finish      = 1'b0;
    resValue    = '0;
    resCarry    = 1'b0;
    resOverflow = 1'b0;
    resIllegal  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          a_d  = bus.a;
          case (bus.op)
            OP_OR: begin
              finish   = 1'b1;
              resValue = bus.a | bus.b;
            end
            OP_AND: begin
              finish   = 1'b1;
              resValue = bus.a & bus.b;
            end
            OP_XOR: begin
              finish   = 1'b1;
              resValue = bus.a ^ bus.b;
            end
            OP_ADD: begin
              finish      = 1'b1;
              resValue    = addSum[WIDTH-1:0];
              resCarry    = addSum[WIDTH];
              resOverflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (addSum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
              finish      = 1'b1;
              resValue    = subDiff[WIDTH-1:0];
              resCarry    = subDiff[WIDTH];
              resOverflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (subDiff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHL, OP_SHR, OP_SRA: begin
              if (shAmt == '0) begin
                finish   = 1'b1;
                resValue = bus.a;
              end else begin
                count_d = {1'b0, shAmt};
                state_d = EXEC;
              end
            end
            OP_MUL: begin
              acc_d   = {{WIDTH{1'b0}}, bus.b};
              count_d = CNTW'(WIDTH);
              state_d = EXEC;
            end
            default: begin
              finish     = 1'b1;
              resIllegal = 1'b1;
            end
          endcase
        end
      end

      // The last step finishes on the same edge the counter drops to zero.
      EXEC: begin
        count_d = count_q - 1'b1;
        if (isShift(op_q)) begin
          a_d = shiftStep;
          if (count_q == CNTW'(1)) begin
            finish   = 1'b1;
            resValue = shiftStep;
            resCarry = shiftOut;
          end
        end else begin
          acc_d = mulStep;
          if (count_q == CNTW'(1)) begin
            finish      = 1'b1;
            resValue    = mulStep[WIDTH-1:0];
            resCarry    = |mulStep[2*WIDTH-1:WIDTH];
            resOverflow = |mulStep[2*WIDTH-1:WIDTH];
          end
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d          = DONE;
      result_d         = resValue;
      flags_d.carry    = resCarry;
      flags_d.negative = resNegative;
      flags_d.zero     = resZero;
      flags_d.parity   = resParity;
      flags_d.overflow = resOverflow;
      flags_d.illegal  = resIllegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = flags_q.carry;
  assign bus.negative  = flags_q.negative;
  assign bus.zero      = flags_q.zero;
  assign bus.parity    = flags_q.parity;
  assign bus.overflow  = flags_q.overflow;
  assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed plus randomized checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

  localparam int WIDTH = 32;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int obsLatency;

  logic [6:0]  rOp;
  logic [31:0] rA, rB, expRes;
  logic [5:0]  expFlags;
  int          expLat;
  logic        sawValid;
  string       tag;

  multicycle_alu_if #(.WIDTH(WIDTH)) bus ();

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      $error("[TB] check %s did not hold", name);
    end
  endtask

  // Flag order: {carry, negative, zero, parity, overflow, illegal}
  function automatic logic [5:0] obsFlags();
    return {bus.carry, bus.negative, bus.zero, bus.parity, bus.overflow, bus.illegal};
  endfunction

  task automatic modelOp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [5:0] fl, output int lat);
    longint sa, sb, wide;
    logic [63:0] prod;
    int n;
    logic c, o, ill;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    n   = int'(b[4:0]);
    c   = 1'b0;
    o   = 1'b0;
    ill = 1'b0;
    lat = 1;
    case (op)
      7'd0: res = a | b;
      7'd1: res = a & b;
      7'd2: res = a ^ b;
      7'd3: begin
        res  = a + b;
        c    = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        wide = sa + sb;
        o    = (wide > MAX_S) || (wide < MIN_S);
      end
      7'd4: begin
        res  = a - b;
        c    = (a < b);
        wide = sa - sb;
        o    = (wide > MAX_S) || (wide < MIN_S);
      end
      7'd5: begin
        res = a << n;
        c   = (n != 0) ? a[32-n] : 1'b0;
        lat = 1 + n;
      end
      7'd6: begin
        res = a >> n;
        c   = (n != 0) ? a[n-1] : 1'b0;
        lat = 1 + n;
      end
      7'd7: begin
        res = $signed(a) >>> n;
        c   = (n != 0) ? a[n-1] : 1'b0;
        lat = 1 + n;
      end
      7'd8: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = prod[31:0];
        c    = |prod[63:32];
        o    = c;
        lat  = 1 + WIDTH;
      end
      default: begin
        res = 32'd0;
        ill = 1'b1;
      end
    endcase
    fl = {c, res[31], (res == 32'd0), ^res, o, ill};
  endtask

  // Offers one operation, then counts edges (accept edge = 1) until out_valid.
  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    checkEq("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    obsLatency = 1;
    while (!bus.out_valid && obsLatency < 100) begin
      @(posedge clk);
      #1;
      obsLatency++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] res, input logic [5:0] fl, input int lat);
    checkEq({name, "_latency"}, obsLatency, lat);
    checkEq({name, "_result"}, bus.result, res);
    checkEq({name, "_flags"}, obsFlags(), fl);
    checkEq({name, "_in_ready_low"}, bus.in_ready, 0);
  endtask

  task automatic drainOutput(input string name);
    @(posedge clk);
    #1;
    checkEq({name, "_out_valid_cleared"}, bus.out_valid, 0);
    checkEq({name, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 7'd3;
    bus.a         = 32'd5;
    bus.b         = 32'd6;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkEq("reset_in_ready", bus.in_ready, 1);
    checkEq("reset_out_valid", bus.out_valid, 0);
    checkEq("reset_result", bus.result, 0);
    checkEq("reset_flags", obsFlags(), 6'b000000);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    applyStimulus(7'd3, 32'd1, 32'd2);
    checkOutput("add_1_2", 32'd3, 6'b000000, 1);
    drainOutput("add_1_2");

    applyStimulus(7'd3, 32'h7FFF_FFFF, 32'd1);
    checkOutput("add_ovf", 32'h8000_0000, 6'b010110, 1);
    drainOutput("add_ovf");

    applyStimulus(7'd4, 32'd0, 32'd1);
    checkOutput("sub_borrow", 32'hFFFF_FFFF, 6'b110000, 1);
    drainOutput("sub_borrow");

    applyStimulus(7'd5, 32'h8000_0001, 32'd1);
    checkOutput("shl_1", 32'd2, 6'b100100, 2);
    drainOutput("shl_1");

    applyStimulus(7'd7, 32'h8000_0000, 32'd31);
    checkOutput("sra_31", 32'hFFFF_FFFF, 6'b010000, 32);
    drainOutput("sra_31");

    applyStimulus(7'd6, 32'h1234_5678, 32'd32);
    checkOutput("shr_amt0", 32'h1234_5678, 6'b000100, 1);
    drainOutput("shr_amt0");

    applyStimulus(7'd8, 32'h0001_0000, 32'h0001_0000);
    checkOutput("mul_wrap", 32'd0, 6'b101010, 33);
    drainOutput("mul_wrap");

    applyStimulus(7'd8, 32'd7, 32'd6);
    checkOutput("mul_7x6", 32'd42, 6'b000100, 33);
    drainOutput("mul_7x6");

    // Back-pressure: result must hold while a new request is ignored
    bus.out_ready = 1'b0;
    applyStimulus(7'd2, 32'hF0F0_0000, 32'h0F0F_0000);
    checkOutput("hold_xor", 32'hFFFF_0000, 6'b010000, 1);
    bus.in_valid = 1'b1;
    bus.op       = 7'd3;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkEq("hold_out_valid", bus.out_valid, 1);
      checkEq("hold_in_ready", bus.in_ready, 0);
      checkEq("hold_result", bus.result, 32'hFFFF_0000);
      checkEq("hold_flags", obsFlags(), 6'b010000);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drainOutput("hold_xor");

    applyStimulus(7'd9, 32'hDEAD_BEEF, 32'h1234_5678);
    checkOutput("illegal_9", 32'd0, 6'b001001, 1);
    drainOutput("illegal_9");

    applyStimulus(7'd4, 32'd5, 32'd7);
    checkOutput("sub_5_7", 32'hFFFF_FFFE, 6'b110100, 1);
    drainOutput("sub_5_7");

    // Abort a multiply partway through with reset
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 7'd8;
    bus.a        = 32'd12345;
    bus.b        = 32'd678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkEq("mul_busy_out_valid", bus.out_valid, 0);
    checkEq("mul_busy_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    checkEq("abort_result", bus.result, 0);
    checkEq("abort_flags", obsFlags(), 6'b000000);
    checkEq("abort_out_valid", bus.out_valid, 0);
    checkEq("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkEq("abort_no_result", sawValid, 0);

    applyStimulus(7'd3, 32'd5, 32'd10);
    checkOutput("add_after_abort", 32'd15, 6'b000000, 1);
    drainOutput("add_after_abort");

    for (int i = 0; i < 40; i++) begin
      rOp = 7'($urandom_range(0, 10));
      rA  = $urandom;
      rB  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rA = 32'h0000_0000;
          1:       rA = 32'hFFFF_FFFF;
          2:       rA = 32'h8000_0000;
          default: rA = 32'h7FFF_FFFF;
        endcase
      end
      modelOp(rOp, rA, rB, expRes, expFlags, expLat);
      tag = $sformatf("rand%0d_op%0d", i, rOp);
      applyStimulus(rOp, rA, rB);
      checkOutput(tag, expRes, expFlags, expLat);
      drainOutput(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked successor to the single-cycle combinational ALU. Accepts one operation at a time through a valid/ready input port. Executes logic, add/subtract, iterative shifts and an iterative shift-add multiply. Returns a registered result and flag set through a valid/ready output port. Sits between the control unit/register-read stage and writeback, and can stall both sides.

## Interface
- `WIDTH`, 32: operand/result width; ≥ 4, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block idle, can accept.
- `op` in 7: opcode (encodings under Operation).
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: operation result.
- `carry`, `negative`, `zero`, `parity`, `overflow`, `illegal` out 1 each: flags.

## Operation
- Opcodes: 0 OR, 1 AND, 2 XOR, 3 ADD, 4 SUB (a−b), 5 SHL, 6 SHR logical, 7 SRA, 8 MUL (low WIDTH bits of a*b, unsigned).
- Any other opcode is illegal: result 0, `illegal`=1, other flags derived from result 0.
- Shift amount is `b[SHW-1:0]`; upper bits of `b` are ignored.
- Flags:
  - `negative` = result[WIDTH-1].
  - `zero` = (result==0).
  - `parity` = XOR of all result bits.
  - ADD: `carry` = carry-out; `overflow` = signed overflow.
  - SUB: `carry` = borrow (1 when a<b unsigned); `overflow` = signed overflow.
  - Shifts: `carry` = last bit shifted out, 0 when amount is 0; `overflow` = 0.
  - MUL: `carry` = `overflow` = (upper WIDTH bits of the full product ≠ 0).
  - Logic ops: `carry` = `overflow` = 0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1. On in_valid&&in_ready, latch op/a/b.
    - Logic, ADD, SUB, illegal: go to DONE.
    - Shifts and MUL: go to EXEC.
    - Shifts with amount 0: go straight to DONE.
  - EXEC, shifts: one bit position per cycle; down-counter loaded with the amount; go to DONE when it reaches 0.
  - EXEC, MUL: one multiplier bit per cycle, LSB first, for WIDTH cycles; 2*WIDTH accumulator.
  - DONE: `out_valid`=1; result and flags held stable. Go to IDLE on out_ready.
- Inputs other than handshakes are ignored outside IDLE.
- `in_valid` may drop without effect while `in_ready`=0.

## Timing
- Reset (async assert, sync-released internally is not required): state IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `result` and all flags 0; counters and accumulator 0.
- Latency, accept edge to `out_valid` high:
  - 1 cycle for logic, ADD, SUB, illegal, and shift amount 0.
  - 1+n cycles for a shift by n.
  - 1+WIDTH cycles for MUL.
- `in_ready` and `out_valid` are never both 1.
- `in_ready` rises the cycle after the output handshake; max throughput is one op per 2 cycles.
- If `out_ready` is held high, DONE lasts exactly one cycle.
- `rst` mid-EXEC or mid-DONE aborts immediately: no result is emitted and the pending result is discarded.
- Width rules:
  - ADD/SUB use a WIDTH+1 internal sum.
  - MUL accumulator is 2*WIDTH; product wrap is reported only via flags.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_OR…OP_MUL), FSM state typedef, flag-bundle struct.
- One natural sub-module, `alu_flags`: combinational negative/zero/parity from the result, parametrised by WIDTH. Carry and overflow are computed in the parent.

## Test plan
- Reset with `in_valid`=1 asserted → `in_ready`=1, `out_valid`=0, all outputs 0; release, ADD a=1 b=2 → `result`=3 one cycle after accept, all flags 0.
- ADD a=32'h7FFF_FFFF b=1 → `result`=32'h8000_0000, `overflow`=1, `negative`=1, `carry`=0; SUB a=0 b=1 → 32'hFFFF_FFFF, `carry`=1, `parity`=0.
- SHL a=32'h8000_0001 b=1 → `result`=2, `carry`=1, latency 2; SRA a=32'h8000_0000 b=31 → 32'hFFFF_FFFF, latency 32; SHR b=32 (amount 0) → `result`=a, latency 1.
- MUL a=32'h0001_0000 b=32'h0001_0000 → `result`=0, `zero`=1, `carry`=`overflow`=1, latency 33; MUL 7×6 → 42, no overflow.
- Hold `out_ready`=0 for 5 cycles after a result → `result`/flags stable, `in_ready`=0, new `in_valid` ignored; op=9 → `illegal`=1, `result`=0, `zero`=1.
- Assert `rst` 10 cycles into a MUL → outputs 0 immediately, no `out_valid`; the next ADD completes normally.
